y86_sequencer: RTL and testbench

Y86_SEQUENCER -- requirements
Module: y86_sequencer

---
 rtl/y86_sequencer.sv | 168 ++++++++++++++++
 tb/tb_y86_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_sequencer.sv
// Multi-cycle fetch/decode sequencer for a Y86 subset (HALT, NOP, RRMOVL, IRMOVL, OPL), one instruction byte per request.
// Latency is instruction bytes + 2 cycles (EXEC, WB); a missing imem_ack stalls the fetch in place.
module y86_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_data,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [31:0] valC,
    output logic        exec_valid,
    output logic        reg_we,
    output logic [31:0] pc,
    output logic        halted,
    output logic        error
);

    localparam logic [2:0] S_FETCH0 = 3'd0;
    localparam logic [2:0] S_FETCH1 = 3'd1;
    localparam logic [2:0] S_FETCHC = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_RRMOVL = 4'h2;
    localparam logic [3:0] IC_IRMOVL = 4'h3;
    localparam logic [3:0] IC_OPL    = 4'h6;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [31:0] valc_q, valc_d;
    // Bytes accepted so far for the current instruction; equals its length by WB.
    logic [2:0]  cnt_q, cnt_d;

    logic fetching;
    logic accept;
    logic writes_reg;

    always_comb begin
        fetching = (state_q == S_FETCH0) || (state_q == S_FETCH1) || (state_q == S_FETCHC);
    end

    assign imem_req  = fetching && !reset;
    assign imem_addr = pc_q + {29'd0, cnt_q};
    assign accept    = imem_req && imem_ack;

    always_comb begin
        writes_reg = (icode_q == IC_RRMOVL) || (icode_q == IC_IRMOVL) || (icode_q == IC_OPL);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH0: begin
                if (accept) begin
                    icode_d = imem_data[7:4];
                    ifun_d  = imem_data[3:0];
                    cnt_d   = 3'd1;
                    case (imem_data[7:4])
                        IC_HALT:   state_d = S_HALTED;
                        IC_NOP:    state_d = S_EXEC;
                        IC_RRMOVL,
                        IC_IRMOVL,
                        IC_OPL:    state_d = S_FETCH1;
                        default:   state_d = S_ERROR;
                    endcase
                end
            end
            S_FETCH1: begin
                if (accept) begin
                    ra_d    = imem_data[7:4];
                    rb_d    = imem_data[3:0];
                    cnt_d   = 3'd2;
                    state_d = (icode_q == IC_IRMOVL) ? S_FETCHC : S_EXEC;
                end
            end
            S_FETCHC: begin
                if (accept) begin
                    cnt_d = cnt_q + 3'd1;
                    // Immediate arrives least-significant byte first.
                    case (cnt_q)
                        3'd2:    valc_d[7:0]   = imem_data;
                        3'd3:    valc_d[15:8]  = imem_data;
                        3'd4:    valc_d[23:16] = imem_data;
                        default: valc_d[31:24] = imem_data;
                    endcase
                    if (cnt_q == 3'd5) begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = pc_q + {29'd0, cnt_q};
                ra_d    = 4'h0;
                rb_d    = 4'h0;
                valc_d  = 32'h0;
                cnt_d   = 3'd0;
                state_d = S_FETCH0;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH0;
            pc_q    <= RESET_PC;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'h0;
            rb_q    <= 4'h0;
            valc_q  <= 32'h0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign icode      = icode_q;
    assign ifun       = ifun_q;
    assign rA         = ra_q;
    assign rB         = rb_q;
    assign valC       = valc_q;
    assign pc         = pc_q;
    assign exec_valid = (state_q == S_EXEC);
    assign reg_we     = (state_q == S_WB) && writes_reg;
    assign halted     = (state_q == S_HALTED);
    assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_y86_sequencer.sv
// Bench for y86_sequencer: table of single-instruction programs plus halt, error, reset-abort and address-wrap sequences.
module tb_y86_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr;
    logic [7:0]  imem_data;
    logic [3:0]  icode, ifun, rA, rB;
    logic [31:0] valC, pc;
    logic        exec_valid, reg_we, halted, error;

    logic        w_req, w_ack;
    logic [31:0] w_addr;
    logic [7:0]  w_data;
    logic [3:0]  w_icode, w_ifun, w_rA, w_rB;
    logic [31:0] w_valC, w_pc;
    logic        w_exec, w_we, w_halted, w_error;

    always #5 clk = ~clk;

    y86_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .exec_valid(exec_valid), .reg_we(reg_we), .pc(pc), .halted(halted), .error(error)
    );

    y86_sequencer #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
        .icode(w_icode), .ifun(w_ifun), .rA(w_rA), .rB(w_rB), .valC(w_valC),
        .exec_valid(w_exec), .reg_we(w_we), .pc(w_pc), .halted(w_halted), .error(w_error)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [31:0] valc;
    } exp_t;

    typedef struct {
        logic [47:0] bytes;   // byte 0 in [7:0]
        int          n;
        int          wt;
        exp_t        e;
        logic        we;
        logic [31:0] pc_after;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[6];
    logic [7:0]  mem[256];
    int          wt = 0;
    bit          spurious = 1'b0;
    int          exec_cnt = 0, we_cnt = 0, acc_cnt = 0;

    // Instruction memory responder with programmable wait states.
    initial begin
        int          wcnt;
        logic [31:0] hold_addr;
        wcnt = 0;
        hold_addr = 32'h0;
        imem_ack = 1'b0;
        imem_data = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req) begin
                if (wcnt == 0) hold_addr = imem_addr;
                else check("addr_hold", imem_addr, hold_addr);
                if (wcnt >= wt) begin
                    imem_ack = 1'b1;
                    imem_data = mem[imem_addr[7:0]];
                    wcnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_data = 8'h00;
                    wcnt++;
                end
            end else begin
                imem_ack = spurious;
                imem_data = spurious ? 8'h10 : 8'h00;
                wcnt = 0;
            end
        end
    end

    // Wrap instance memory: 20 at 0xFFFFFFFF, 12 at 0, HALT elsewhere.
    initial begin
        w_ack = 1'b0;
        w_data = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            w_ack = w_req;
            w_data = (w_addr == 32'hFFFF_FFFF) ? 8'h20 : ((w_addr == 32'h0) ? 8'h12 : 8'h00);
        end
    end

    // Scoreboard: every exec_valid pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (imem_req && imem_ack) acc_cnt++;
            if (reg_we) we_cnt++;
            if (exec_valid) begin
                exec_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exec: got icode %h pc %h expected no exec_valid", icode, pc);
                end else begin
                    e = sb_q.pop_front();
                    check("exec_icode", 32'(icode), 32'(e.icode));
                    check("exec_ifun", 32'(ifun), 32'(e.ifun));
                    check("exec_rA", 32'(rA), 32'(e.ra));
                    check("exec_rB", 32'(rB), 32'(e.rb));
                    check("exec_valC", valC, e.valc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs();
        check("rst_pc", pc, 32'h0);
        check("rst_fields", 32'({icode, ifun, rA, rB}), 32'h0);
        check("rst_valC", valC, 32'h0);
        check("rst_ctl", 32'({imem_req, exec_valid, reg_we, halted, error}), 32'h0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFF);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input logic [47:0] bytes, input int n);
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        for (int k = 0; k < n; k++) mem[k] = bytes[8*k +: 8];
    endtask

    task automatic set_vec(input int i, input logic [47:0] bytes, input int n, input int w,
                           input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [31:0] vc, input logic we,
                           input logic [31:0] pca);
        vecs[i].bytes = bytes;
        vecs[i].n = n;
        vecs[i].wt = w;
        vecs[i].e.icode = ic;
        vecs[i].e.ifun = fn;
        vecs[i].e.ra = ra;
        vecs[i].e.rb = rb;
        vecs[i].e.valc = vc;
        vecs[i].we = we;
        vecs[i].pc_after = pca;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit found;
        do_reset();
        load(v.bytes, v.n);
        wt = v.wt;
        sb_q.push_back(v.e);
        acc_cnt = 0;
        reset = 1'b0;
        cyc = 1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #3;
            cyc++;
            if (exec_valid) found = 1'b1;
        end
        check("exec_seen", 32'(found), 32'd1);
        check("exec_cycle", 32'(cyc), 32'(v.n * (v.wt + 1) + 1));
        check("accepts", 32'(acc_cnt), 32'(v.n));
        @(negedge clk);
        #3;
        check("wb_reg_we", 32'(reg_we), 32'(v.we));
        check("exec_one_cycle", 32'(exec_valid), 32'd0);
        @(negedge clk);
        #3;
        check("pc_after", pc, v.pc_after);
        check("next_req", 32'(imem_req), 32'd1);
        check("next_addr", imem_addr, v.pc_after);
        check("cleared_regs", 32'({rA, rB}), 32'h0);
        check("cleared_valC", valC, 32'h0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        bit   found, any_req;
        int   exec0, we0;
        reset = 1'b1;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;

        set_vec(0, 48'h12_34_56_78_F2_30, 6, 0, 4'h3, 4'h0, 4'hF, 4'h2, 32'h1234_5678, 1'b1, 32'd6);
        set_vec(1, 48'h12_60,             2, 3, 4'h6, 4'h0, 4'h1, 4'h2, 32'h0,         1'b1, 32'd2);
        set_vec(2, 48'h10,                1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 32'h0,         1'b0, 32'd1);
        set_vec(3, 48'h34_20,             2, 1, 4'h2, 4'h0, 4'h3, 4'h4, 32'h0,         1'b1, 32'd2);
        set_vec(4, 48'hAB_61,             2, 0, 4'h6, 4'h1, 4'hA, 4'hB, 32'h0,         1'b1, 32'd2);
        set_vec(5, 48'hDE_AD_BE_EF_83_30, 6, 2, 4'h3, 4'h0, 4'h8, 4'h3, 32'hDEAD_BEEF, 1'b1, 32'd6);

        @(negedge clk);
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // NOP then HALT: halted sticks at pc 1 with no further requests.
        do_reset();
        load(48'h00_10, 2);
        wt = 0;
        e.icode = 4'h1; e.ifun = 4'h0; e.ra = 4'h0; e.rb = 4'h0; e.valc = 32'h0;
        sb_q.push_back(e);
        we0 = we_cnt;
        reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            #3;
            if (halted) found = 1'b1;
        end
        check("halt_seen", 32'(found), 32'd1);
        check("halt_pc", pc, 32'd1);
        check("nop_no_we", 32'(we_cnt - we0), 32'd0);
        any_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #3;
            any_req |= imem_req;
        end
        check("halt_no_req", 32'(any_req), 32'd0);
        check("halt_sticky", 32'({halted, error}), 32'b10);
        check("halt_pc_hold", pc, 32'd1);

        // Illegal opcode with ack pulses arriving while no request is open.
        do_reset();
        load(48'hF0, 1);
        spurious = 1'b1;
        exec0 = exec_cnt;
        reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            #3;
            if (error) found = 1'b1;
        end
        check("error_seen", 32'(found), 32'd1);
        check("error_pc", pc, 32'd0);
        check("error_icode", 32'(icode), 32'hF);
        any_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #3;
            any_req |= imem_req;
        end
        check("error_no_req", 32'(any_req), 32'd0);
        check("error_sticky", 32'({halted, error}), 32'b01);
        check("error_pc_hold", pc, 32'd0);
        check("error_no_exec", 32'(exec_cnt - exec0), 32'd0);
        spurious = 1'b0;

        // Reset during FETCHC after two immediate bytes aborts the instruction.
        do_reset();
        load(48'h12_34_56_78_F2_30, 6);
        wt = 0;
        exec0 = exec_cnt;
        we0 = we_cnt;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("abort_pre_addr", imem_addr, 32'd4);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        check("abort_no_exec", 32'(exec_cnt - exec0), 32'd0);
        check("abort_no_we", 32'(we_cnt - we0), 32'd0);
        reset = 1'b0;
        #2;
        check("abort_restart", {imem_req, imem_addr[30:0]}, 32'h8000_0000);
        check("abort_restart_hi", 32'(imem_addr[31]), 32'd0);

        // PC wrap: second byte comes from address 0.
        do_reset();
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        reset = 1'b0;
        @(negedge clk);
        #3;
        check("wrap_req", 32'(w_req), 32'd1);
        check("wrap_addr", w_addr, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            #3;
            if (w_exec) check("wrap_fields", 32'({w_icode, w_rA, w_rB}), 32'h212);
            if (w_halted) found = 1'b1;
        end
        check("wrap_halt_seen", 32'(found), 32'd1);
        check("wrap_pc", w_pc, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
